lsu: RTL and testbench

Load/store unit placed directly upstream of the data `ram`. It accepts one byte, half, word or doubleword access per request and converts it into the word-granular read/write cycles the RAM needs. Sub-word stores become single-cycle read-modify-writes. Accesses that straddle two RAM words are split into two phases. Load data is sign- or zero-extended and returned with a one-cycle completion pulse.

---
 rtl/lsu_if.sv | 31 +++
 rtl/lsu.sv | 111 +++++++++++
 tb/tb_lsu.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if: request/response and RAM-side signals of the load/store unit.
//   master: request source and RAM data return (drives req_*, ram_dout)
//   slave : the lsu itself (drives req_ready, resp_*, ram_we/ram_adr/ram_din)
interface lsu_if #(
    parameter int N = 10,
    parameter int M = 64
);
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [N-1:0] req_addr;
    logic [M-1:0] req_wdata;
    logic         resp_valid;
    logic [M-1:0] resp_rdata;
    logic         ram_we;
    logic [N-1:0] ram_adr;
    logic [M-1:0] ram_din;
    logic [M-1:0] ram_dout;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        input  req_ready, resp_valid, resp_rdata, ram_we, ram_adr, ram_din
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_dout,
        output req_ready, resp_valid, resp_rdata, ram_we, ram_adr, ram_din
    );
endinterface

// File: rtl/lsu.sv
// lsu: byte/half/word/double load-store unit in front of a word-wide RAM.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_if.slave - request (req_*), completion (resp_*), RAM (ram_*)
// Sub-word stores are read-modify-writes against the combinational ram_dout;
// accesses crossing a word boundary take a second phase on the next word.
module lsu #(
    parameter int N           = 10,
    parameter int M           = 64,
    parameter int OFFSET_BITS = 3
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    localparam int B = M / 8;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             addr_q, addr_d;
    logic [1:0]               size_q, size_d;
    logic                     we_q, we_d, uns_q, uns_d;
    logic [M-1:0]             wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
    logic                     valid_q, valid_d;
    logic [N-OFFSET_BITS-1:0] word;
    logic [M-1:0]             ext;
    logic                     span;
    int                       o, nb;

    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;

    always_comb begin
        o           = int'(addr_q[OFFSET_BITS-1:0]);
        nb          = 1 << size_q;
        span        = o + nb > B;
        word        = addr_q[N-1:OFFSET_BITS];
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        bus.req_ready = state_q == IDLE;
        bus.ram_we  = we_q && (state_q == ACC0 || state_q == ACC1);
        bus.ram_adr = '0;
        bus.ram_din = '0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                state_d = ACC0;
                addr_d  = bus.req_addr;
                size_d  = bus.req_size;
                we_d    = bus.req_we;
                uns_d   = bus.req_unsigned;
                wdata_d = bus.req_wdata;
            end
            ACC0: begin
                state_d     = span ? ACC1 : DONE;
                bus.ram_adr = {word, {OFFSET_BITS{1'b0}}};
                bus.ram_din = we_q ? bus.ram_dout : '0;
                // first phase covers bytes off..min(off+bytes, B)-1 of this word
                for (int i = 0; i < B; i++)
                    if (i >= o && i < o + nb) begin
                        if (we_q) bus.ram_din[8*i+:8] = wdata_q[8*(i-o)+:8];
                        else buf_d[8*(i-o)+:8] = bus.ram_dout[8*i+:8];
                    end
            end
            ACC1: begin
                state_d     = DONE;
                bus.ram_adr = {word + (N-OFFSET_BITS)'(1), {OFFSET_BITS{1'b0}}};
                bus.ram_din = we_q ? bus.ram_dout : '0;
                // second phase holds the overflow bytes from byte 0 of the next word
                for (int i = 0; i < B; i++)
                    if (i < o + nb - B) begin
                        if (we_q) bus.ram_din[8*i+:8] = wdata_q[8*(i+B-o)+:8];
                        else buf_d[8*(i+B-o)+:8] = bus.ram_dout[8*i+:8];
                    end
            end
            default: state_d = IDLE;
        endcase
        ext = '0;
        for (int k = 0; k < M; k++)
            ext[k] = k < 8*nb ? buf_d[k] : buf_d[8*nb-1] & ~uns_q;
        valid_d = state_d == DONE;
        rdata_d = (state_d == DONE && !we_q) ? ext : rdata_q;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed plus random checks of lsu against a byte-array reference memory.
module tb_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.N(10), .M(64)) bus();
    lsu #(.N(10), .M(64), .OFFSET_BITS(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    logic [7:0]  mem [1024] = '{default: 8'h00};
    logic [7:0]  ref_mem [1024];
    logic [63:0] last_rd;
    int          total = 0;
    int          bad = 0;

    always_comb begin
        bus.ram_dout = '0;
        for (int i = 0; i < 8; i++) bus.ram_dout[8*i+:8] = mem[{bus.ram_adr[9:3], 3'(i)}];
    end

    always @(posedge clk)
        if (bus.ram_we)
            for (int i = 0; i < 8; i++) mem[{bus.ram_adr[9:3], 3'(i)}] <= bus.ram_din[8*i+:8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mw(input int a);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v[8*i+:8] = mem[(a & ~7) + i];
        return v;
    endfunction

    function automatic logic [63:0] model_load(input int a, input int s, input logic u);
        int nb = 1 << s;
        logic [63:0] v = '0;
        for (int i = 0; i < nb; i++) v[8*i+:8] = ref_mem[(a + i) % 1024];
        if (s != 3 && !u && v[8*nb-1]) for (int k = 8*nb; k < 64; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic op(input string tag, input logic we, input int s, input logic u,
                      input int a, input logic [63:0] wd);
        int nb = 1 << s;
        bit sp = (a % 8) + nb > 8;
        int lat = 0;
        int writes = 0;
        int k = 0;
        logic [9:0] a1 = '0;
        logic [9:0] a2 = '0;
        logic [63:0] exp_rd = model_load(a, s, u);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = 2'(s);
        bus.req_unsigned = u;
        bus.req_addr = 10'(a);
        bus.req_wdata = wd;
        @(posedge clk);
        while (k < 8 && lat == 0) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            k++;
            if (k == 1) chk({tag, " ready_busy"}, 64'(bus.req_ready), 64'd0);
            if (bus.ram_we) writes++;
            if (k == 1) a1 = bus.ram_adr;
            if (k == 2) a2 = bus.ram_adr;
            if (bus.resp_valid) lat = k;
        end
        last_rd = bus.resp_rdata;
        chk({tag, " latency"}, 64'(lat), sp ? 64'd3 : 64'd2);
        chk({tag, " writes"}, 64'(writes), !we ? 64'd0 : sp ? 64'd2 : 64'd1);
        chk({tag, " adr0"}, 64'(a1), 64'(a & ~7));
        if (sp) chk({tag, " adr1"}, 64'(a2), 64'(((a & ~7) + 8) % 1024));
        if (we) for (int i = 0; i < nb; i++) ref_mem[(a + i) % 1024] = wd[8*i+:8];
        else chk({tag, " rdata"}, last_rd, exp_rd);
        @(negedge clk);
        chk({tag, " pulse"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, " ready_idle"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd3;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 10'h010;
        bus.req_wdata = '1;
        last_rd = '0;

        repeat (3) begin
            @(negedge clk);
            chk("rst ready", 64'(bus.req_ready), 64'd1);
            chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
            chk("rst ram_we", 64'(bus.ram_we), 64'd0);
            chk("rst rdata", bus.resp_rdata, 64'd0);
        end
        rst = 1'b0;
        bus.req_valid = 1'b0;
        chk("rst no_write", mw(16'h010), 64'd0);

        op("SD 010", 1'b1, 3, 1'b0, 'h010, 64'h1122334455667788);
        op("LD 010", 1'b0, 3, 1'b0, 'h010, '0);
        chk("LD 010 const", last_rd, 64'h1122334455667788);

        op("SB 013", 1'b1, 0, 1'b0, 'h013, 64'hAB);
        chk("SB 013 word", mw('h010), 64'h11223344AB667788);
        op("LB 013", 1'b0, 0, 1'b0, 'h013, '0);
        chk("LB 013 const", last_rd, 64'hFFFFFFFFFFFFFFAB);
        op("LBU 013", 1'b0, 0, 1'b1, 'h013, '0);
        chk("LBU 013 const", last_rd, 64'h00000000000000AB);

        op("SD 018", 1'b1, 3, 1'b0, 'h018, 64'h99AABBCCDDEEFF00);
        op("LW 016", 1'b0, 2, 1'b0, 'h016, '0);
        chk("LW 016 const", last_rd, 64'hFFFFFFFFFF001122);
        op("LWU 016", 1'b0, 2, 1'b1, 'h016, '0);
        chk("LWU 016 const", last_rd, 64'h00000000FF001122);

        op("SH 3FF", 1'b1, 1, 1'b0, 'h3FF, 64'hBEEF);
        chk("SH 3FF hi", 64'(mem[10'h3FF]), 64'hEF);
        chk("SH 3FF wrap", 64'(mem[10'h000]), 64'hBE);
        op("LH 3FF", 1'b0, 1, 1'b0, 'h3FF, '0);
        chk("LH 3FF const", last_rd, 64'hFFFFFFFFFFFFBEEF);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_size = 2'd3;
        bus.req_addr = 10'h01C;
        bus.req_wdata = '1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid acc0 we", 64'(bus.ram_we), 64'd1);
        chk("mid acc0 adr", 64'(bus.ram_adr), 64'h018);
        @(negedge clk);
        chk("mid acc1 adr", 64'(bus.ram_adr), 64'h020);
        rst = 1'b1;
        #1;
        chk("mid rst we", 64'(bus.ram_we), 64'd0);
        chk("mid rst ready", 64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 4; i++) ref_mem['h01C + i] = 8'hFF;
        repeat (2) begin
            @(negedge clk);
            chk("mid no resp", 64'(bus.resp_valid), 64'd0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("mid after resp", 64'(bus.resp_valid), 64'd0);
        end
        chk("mid word 018", mw('h018), 64'hFFFFFFFFDDEEFF00);
        chk("mid word 020", mw('h020), 64'h0);

        for (int n = 0; n < 80; n++) begin
            logic we = 1'($urandom_range(0, 1));
            int s = int'($urandom_range(0, 3));
            int a = (n % 4 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range('h100, 'h13F));
            op($sformatf("rnd%0d", n), we, s, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        for (int w = 0; w < 1024; w += 8) begin
            logic [63:0] e = '0;
            for (int i = 0; i < 8; i++) e[8*i+:8] = ref_mem[w + i];
            chk($sformatf("mem %03h", w), mw(w), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
